// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The master modport is the loader side; slave is the host/memory side.
interface imem_loader_if #(
  parameter int ADDR_W = 12
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              wren;

  modport master (
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output wr_addr,
    output wr_data,
    output wren
  );

  modport slave (
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  wr_addr,
    input  wr_data,
    input  wren
  );
endinterface

// File: rtl/imem_loader.sv
// Serial program loader: length header, big-endian words written to instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to add a trailing XOR checksum byte (CHK state).
module imem_loader #(
  parameter int ADDR_W    = 12,
  parameter int MAX_WORDS = 4096
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  imem_loader_if.master   bus,
  output logic            proc_hold,
  output logic            done,
  output logic            err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [7:0]        len_hi_reg, len_hi_next;
  logic [15:0]       len_reg, len_next;
  logic [1:0]        byte_cnt_reg, byte_cnt_next;
  logic [31:0]       word_reg, word_next;
  logic [ADDR_W-1:0] word_idx_reg, word_idx_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [31:0]       wr_data_reg, wr_data_next;
  logic              wren_reg, wren_next;
  logic              byte_ready_reg, byte_ready_next;
  logic              proc_hold_reg, proc_hold_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        chk_reg, chk_next;
`endif

  logic        accept;
  logic        last_word;
  logic        len_bad;
  logic [15:0] len_full;
  logic [31:0] word_fill;

  assign accept    = byte_ready_reg & bus.byte_valid;
  assign len_full  = {len_hi_reg, bus.byte_in};
  assign len_bad   = (len_full == 16'd0) || (32'(len_full) > 32'(MAX_WORDS));
  assign last_word = (32'(word_idx_reg) == (32'(len_reg) - 32'd1));

  // Byte counter value k steers the incoming byte into lane 3-k (first byte -> [31:24]).
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign word_fill[gi*8 +: 8] = (byte_cnt_reg == 2'(3 - gi)) ? bus.byte_in
                                                                : word_reg[gi*8 +: 8];
  end

  always_comb begin
    state_next    = state_reg;
    len_hi_next   = len_hi_reg;
    len_next      = len_reg;
    byte_cnt_next = byte_cnt_reg;
    word_next     = word_reg;
    word_idx_next = word_idx_reg;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;
    err_next      = err_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_next      = chk_reg;
`endif

    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next    = S_LEN_HI;
          word_idx_next = '0;
          byte_cnt_next = 2'd0;
          err_next      = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_next      = 8'd0;
`endif
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_hi_next = bus.byte_in;
          state_next  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_next = len_full;
          if (len_bad) begin
            err_next   = 1'b1;
            state_next = S_DONE;
          end else begin
            state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          word_next     = word_fill;
          byte_cnt_next = byte_cnt_reg + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_next      = chk_reg ^ bus.byte_in;
`endif
          if (byte_cnt_reg == 2'd3) begin
            state_next   = S_WRITE;
            wr_addr_next = word_idx_reg;
            wr_data_next = word_fill;
          end
        end
      end
      S_WRITE: begin
        // wr_addr is only loaded in DATA, so a wrap of the index past the last word is harmless.
        word_idx_next = word_idx_reg + 1'b1;
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_next = S_CHK;
`else
          state_next = S_DONE;
`endif
        end else begin
          state_next = S_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          err_next   = (bus.byte_in != chk_reg);
          state_next = S_DONE;
        end
      end
`endif
      default: state_next = S_IDLE;
    endcase

    // Status outputs are registered copies of what the next state implies.
    wren_next       = (state_next == S_WRITE);
    proc_hold_next  = (state_next != S_IDLE) && (state_next != S_DONE);
    byte_ready_next = proc_hold_next && (state_next != S_WRITE);
    done_next       = (state_next == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      len_hi_reg     <= 8'd0;
      len_reg        <= 16'd0;
      byte_cnt_reg   <= 2'd0;
      word_reg       <= 32'd0;
      word_idx_reg   <= '0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= 32'd0;
      wren_reg       <= 1'b0;
      byte_ready_reg <= 1'b0;
      proc_hold_reg  <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_reg        <= 8'd0;
`endif
    end else begin
      state_reg      <= state_next;
      len_hi_reg     <= len_hi_next;
      len_reg        <= len_next;
      byte_cnt_reg   <= byte_cnt_next;
      word_reg       <= word_next;
      word_idx_reg   <= word_idx_next;
      wr_addr_reg    <= wr_addr_next;
      wr_data_reg    <= wr_data_next;
      wren_reg       <= wren_next;
      byte_ready_reg <= byte_ready_next;
      proc_hold_reg  <= proc_hold_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_reg        <= chk_next;
`endif
    end
  end

  assign bus.byte_ready = byte_ready_reg;
  assign bus.wr_addr    = wr_addr_reg;
  assign bus.wr_data    = wr_data_reg;
  assign bus.wren       = wren_reg;
  assign proc_hold      = proc_hold_reg;
  assign done           = done_reg;
  assign err            = err_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: table of whole-program loads plus reset-abort and restart sequences.
module tb_imem_loader;

  logic clock;
  logic reset;
  logic start;
  logic proc_hold;
  logic done;
  logic err;

  imem_loader_if #(.ADDR_W(12)) bus ();

  imem_loader #(.ADDR_W(12), .MAX_WORDS(4096)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .proc_hold (proc_hold),
    .done      (done),
    .err       (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0]      len;
    int               nwords;
    logic [2:0][31:0] w;
    logic [7:0]       chk;
    bit               gap;
    bit               exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [11:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic        wr_rdy_q[$];

  always @(negedge clock) begin
    if (bus.wren === 1'b1) begin
      wa_q.push_back(bus.wr_addr);
      wd_q.push_back(bus.wr_data);
      wr_rdy_q.push_back(bus.byte_ready);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] len, input int nwords,
                              input logic [31:0] w2, input logic [31:0] w1, input logic [31:0] w0,
                              input logic [7:0] chk, input bit gap, input bit exp_err);
    vec_t v;
    v.len     = len;
    v.nwords  = nwords;
    v.w       = {w2, w1, w0};
    v.chk     = chk;
    v.gap     = gap;
    v.exp_err = exp_err;
    return v;
  endfunction

  // Present one byte until the loader takes it; with gap, leave byte_valid low for one cycle after.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit acc = 1'b0;
    for (int n = 0; n < 40 && !acc; n++) begin
      @(negedge clock);
      bus.byte_in    = b;
      bus.byte_valid = 1'b1;
      acc            = (bus.byte_ready === 1'b1);
    end
    if (!acc) begin
      errors++;
      $display("FAIL byte_accept_timeout actual=0 required=1 byte=%0h", b);
    end
    if (gap) begin
      @(negedge clock);
      bus.byte_valid = 1'b0;
    end
  endtask

  task automatic pulse_start(input string tag);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check({tag, "_done_after_start"}, 32'(done), 32'd0);
    check({tag, "_hold_after_start"}, 32'(proc_hold), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int base;
    int nwr;
    base = wa_q.size();
    pulse_start(tag);
    send_byte(v.len[15:8], v.gap);
    send_byte(v.len[7:0], v.gap);
    for (int i = 0; i < v.nwords; i++)
      for (int b = 0; b < 4; b++)
        send_byte(v.w[i][8*(3-b) +: 8], v.gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (v.nwords > 0) send_byte(v.chk, v.gap);
`endif
    @(negedge clock);
    bus.byte_valid = 1'b0;
    for (int n = 0; n < 40 && done !== 1'b1; n++) @(negedge clock);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_err"}, 32'(err), 32'(v.exp_err));
    check({tag, "_hold"}, 32'(proc_hold), 32'd0);
    check({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
    nwr = wa_q.size() - base;
    check({tag, "_nwrites"}, 32'(nwr), 32'(v.nwords));
    for (int i = 0; i < v.nwords && i < nwr; i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(wa_q[base+i]), 32'(i));
      check($sformatf("%s_data%0d", tag, i), wd_q[base+i], v.w[i]);
      check($sformatf("%s_rdy_in_write%0d", tag, i), 32'(wr_rdy_q[base+i]), 32'd0);
    end
    $display("load %s len=%0h writes=%0d done=%0b err=%0b", tag, v.len, nwr, done, err);
  endtask

  initial begin
    vec_t vecs[6];
    int   base;
    bit   chk_on;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_on = 1'b1;
`else
    chk_on = 1'b0;
`endif
    //          len       n  w2            w1            w0            chk    gap  err
    vecs[0] = mk(16'h0001, 1, 32'h0,        32'h0,        32'h12345678, 8'h08, 1'b0, 1'b0);
    vecs[1] = mk(16'h0003, 3, 32'h99AABBCC, 32'h55667788, 32'h11223344, 8'hCC, 1'b1, 1'b0);
    vecs[2] = mk(16'h0000, 0, 32'h0,        32'h0,        32'h0,        8'h00, 1'b0, 1'b1);
    vecs[3] = mk(16'h1001, 0, 32'h0,        32'h0,        32'h0,        8'h00, 1'b0, 1'b1);
    vecs[4] = mk(16'h0001, 1, 32'h0,        32'h0,        32'hAABBCCDD, 8'h00, 1'b0, 1'b0);
    vecs[5] = mk(16'h0001, 1, 32'h0,        32'h0,        32'hAABBCCDD, 8'h01, 1'b0, chk_on);

    reset          = 1'b1;
    start          = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_ready", 32'(bus.byte_ready), 32'd0);
    check("rst_wren", 32'(bus.wren), 32'd0);
    check("rst_addr", 32'(bus.wr_addr), 32'd0);
    check("rst_data", bus.wr_data, 32'd0);
    check("rst_hold", 32'(proc_hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    $display("reset outputs idle");
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Abort a 3-word load with reset after two words have been written.
    base = wa_q.size();
    pulse_start("abort");
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    for (int i = 0; i < 10; i++) send_byte(8'(8'h40 + i), 1'b0);
    @(negedge clock);
    reset       = 1'b1;
    bus.byte_in = 8'hEE;
    @(negedge clock);
    check("abort_ready", 32'(bus.byte_ready), 32'd0);
    check("abort_wren", 32'(bus.wren), 32'd0);
    check("abort_addr", 32'(bus.wr_addr), 32'd0);
    check("abort_data", bus.wr_data, 32'd0);
    check("abort_hold", 32'(proc_hold), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    bus.byte_valid = 1'b0;
    check("abort_nwrites", 32'(wa_q.size() - base), 32'd2);
    check("abort_idle_ready", 32'(bus.byte_ready), 32'd0);
    $display("abort writes=%0d", wa_q.size() - base);

    // Recovery from IDLE, then restart from DONE.
    run_vec(vecs[0], "recover");
    run_vec(vecs[4], "restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
